// File: rtl/ip_uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// ip_uart_arb_pkg
//   Shared definitions for the ip_uart transmit arbiter.
//   - arb_state_t : arbiter FSM state encoding
//                   (ST_IDLE=0, ST_SEND=1, ST_WAIT_ACK=2, ST_WAIT_DONE=3)
//   - UART_BYTE_W : width of one byte handed to ip_uart
//   - cnt_width() : counter width able to hold a terminal value (min 1 bit)
// ---------------------------------------------------------------------------
package ip_uart_arb_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    // Width of a counter that must be able to reach 'limit' itself.
    function automatic int cnt_width(input int limit);
        int w;
        w = 1;
        while ((limit >> w) != 0) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ip_uart_rr_pick.sv
// ---------------------------------------------------------------------------
// ip_uart_rr_pick
//   Combinational rotate / priority-find / rotate-back picker. Finds the first
//   set request at or above 'ptr', wrapping modulo NUM_REQ.
//
//   Build option: `define UART_ARB_FIXED_PRIO_EN ties the effective pointer to
//   0, giving fixed priority with the lowest index winning.
//
// Ports
//   req  in  NUM_REQ  request vector
//   ptr  in  PTR_W    index that has highest priority this round
//   gnt  out NUM_REQ  one-hot winner (all zero when req is zero)
//   idx  out PTR_W    index of the winner (0 when req is zero)
// ---------------------------------------------------------------------------
module ip_uart_rr_pick
    import ip_uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx
);

    logic [PTR_W-1:0]     ptr_eff;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 found;
    int                   rot_idx;
    int                   win_idx;

    always_comb begin
`ifdef UART_ARB_FIXED_PRIO_EN
        // Masking keeps the port meaningful while forcing priority to index 0.
        ptr_eff = ptr & {PTR_W{1'b0}};
`else
        ptr_eff = ptr;
`endif
        // Rotate so that the pointer position lands on bit 0.
        req_dbl = {req, req} >> ptr_eff;
        req_rot = req_dbl[NUM_REQ-1:0];

        found   = 1'b0;
        rot_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_rot[i]) begin
                found   = 1'b1;
                rot_idx = i;
            end
        end

        // Rotate the winner back into absolute index space.
        win_idx = rot_idx + int'(ptr_eff);
        if (win_idx >= NUM_REQ) begin
            win_idx = win_idx - NUM_REQ;
        end

        idx = found ? PTR_W'(win_idx) : '0;
        gnt = found ? (NUM_REQ'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/ip_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ip_uart_tx_arbiter
//   Shares one ip_uart transmitter between NUM_REQ byte sources. A requester
//   is granted (round-robin from an internal pointer) and keeps the grant until
//   its packet ends on req_last, so packets never interleave. Each byte is
//   handed over with a one-cycle send_req pulse, then the arbiter waits for
//   send_busy to rise (or ACK_TIMEOUT cycles) and fall again.
//
//   Build option: `define UART_ARB_FIXED_PRIO_EN selects fixed priority (lowest
//   index wins, pointer held at 0). Default build is round-robin.
//
// Valid/ready: a byte of requester i transfers on a rising sys_clk edge where
//   req_valid[i] and req_ready[i] are both high. req_ready is combinational and
//   only ever high for the current owner, in SEND, while send_busy is low.
//   A requester must hold req_data/req_last stable while req_valid is high and
//   req_ready is low.
//
// Ports
//   sys_clk    in  1          system clock
//   w_n_reset  in  1          asynchronous active-low reset
//   req_valid  in  NUM_REQ    requester i has a byte
//   req_data   in  NUM_REQ*8  byte of requester i in bits [8i+7:8i]
//   req_last   in  NUM_REQ    byte of requester i ends its packet
//   req_ready  out NUM_REQ    byte of requester i accepted this cycle
//   grant      out NUM_REQ    one-hot current owner, zero when idle
//   arb_busy   out 1          FSM not in IDLE
//   send_data  out 8          byte to ip_uart
//   send_req   out 1          one-cycle start pulse to ip_uart
//   send_busy  in  1          ip_uart busy
// ---------------------------------------------------------------------------
module ip_uart_tx_arbiter
    import ip_uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ACK_TIMEOUT  = 16,
    parameter int IDLE_TIMEOUT = 1048576
) (
    input  logic                           sys_clk,
    input  logic                           w_n_reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           arb_busy,
    output logic [UART_BYTE_W-1:0]         send_data,
    output logic                           send_req,
    input  logic                           send_busy
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int ACK_W  = cnt_width(ACK_TIMEOUT);
    localparam int IDLE_W = cnt_width(IDLE_TIMEOUT);

    localparam logic [ACK_W-1:0]  ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(NUM_REQ - 1);

    arb_state_t             state_q,     state_d;
    logic [NUM_REQ-1:0]     grant_q,     grant_d;
    logic [PTR_W-1:0]       owner_q,     owner_d;
    logic [PTR_W-1:0]       ptr_q,       ptr_d;
    logic [UART_BYTE_W-1:0] send_data_q, send_data_d;
    logic                   send_req_q,  send_req_d;
    logic                   last_q,      last_d;
    logic [ACK_W-1:0]       ack_cnt_q,   ack_cnt_d;
    logic [IDLE_W-1:0]      idle_cnt_q,  idle_cnt_d;

    logic [NUM_REQ-1:0]     pick_gnt;
    logic [PTR_W-1:0]       pick_idx;
    logic                   owner_valid;
    logic [UART_BYTE_W-1:0] owner_byte;
    logic                   owner_last;
    logic [PTR_W-1:0]       next_ptr;
    logic                   release_pkt;

    ip_uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Owner-side view of the request bus.
    assign owner_valid = |(grant_q & req_valid);
    assign owner_byte  = req_data[int'(owner_q)*UART_BYTE_W +: UART_BYTE_W];
    assign owner_last  = req_last[owner_q];

`ifdef UART_ARB_FIXED_PRIO_EN
    assign next_ptr = '0;
`else
    assign next_ptr = (owner_q == PTR_MAX) ? '0 : owner_q + PTR_W'(1);
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        send_data_d = send_data_q;
        send_req_d  = 1'b0;
        last_d      = last_q;
        ack_cnt_d   = ack_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        req_ready   = '0;
        release_pkt = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_d    = pick_gnt;
                    owner_d    = pick_idx;
                    idle_cnt_d = '0;
                    state_d    = ST_SEND;
                end
            end

            ST_SEND: begin
                // A busy UART (e.g. still shifting a frame from before a
                // reset) stalls the handover entirely.
                req_ready = grant_q & req_valid & {NUM_REQ{~send_busy}};
                if (owner_valid && !send_busy) begin
                    send_data_d = owner_byte;
                    send_req_d  = 1'b1;
                    last_d      = owner_last;
                    idle_cnt_d  = '0;
                    ack_cnt_d   = '0;
                    state_d     = ST_WAIT_ACK;
                end else if (!owner_valid && (IDLE_TIMEOUT != 0)) begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    if (idle_cnt_d == IDLE_LIM) begin
                        release_pkt = 1'b1;
                    end
                end
            end

            ST_WAIT_ACK: begin
                // Leaving after ACK_TIMEOUT quiet cycles covers a UART that
                // completes a byte without busy ever being observed.
                if (send_busy || (ack_cnt_q == ACK_LAST)) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_W'(1);
                end
            end

            ST_WAIT_DONE: begin
                if (!send_busy) begin
                    if (last_q) begin
                        release_pkt = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (release_pkt) begin
            grant_d    = '0;
            ptr_d      = next_ptr;
            idle_cnt_d = '0;
            state_d    = ST_IDLE;
        end
    end

    always_ff @(posedge sys_clk or negedge w_n_reset) begin
        if (!w_n_reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            ptr_q       <= '0;
            send_data_q <= '0;
            send_req_q  <= 1'b0;
            last_q      <= 1'b0;
            ack_cnt_q   <= '0;
            idle_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            send_data_q <= send_data_d;
            send_req_q  <= send_req_d;
            last_q      <= last_d;
            ack_cnt_q   <= ack_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign arb_busy  = (state_q != ST_IDLE);
    assign send_data = send_data_q;
    assign send_req  = send_req_q;

endmodule

// File: tb/tb_ip_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ip_uart_tx_arbiter
//   Directed bench for ip_uart_tx_arbiter (NUM_REQ=4, ACK_TIMEOUT=16,
//   IDLE_TIMEOUT=100). Requesters are byte FIFOs in the bench; a packet-level
//   model orders whole packets by the arbitration rule and fills exp_q with
//   {owner, byte} for every send_req pulse. Honours UART_ARB_FIXED_PRIO_EN.
// ---------------------------------------------------------------------------
module tb_ip_uart_tx_arbiter;

    localparam int N      = 4;
    localparam int ACK_T  = 16;
    localparam int IDLE_T = 100;
    localparam int DEPTH  = 32;

    logic           sys_clk = 1'b0;
    logic           w_n_reset = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           arb_busy;
    logic [7:0]     send_data;
    logic           send_req;
    logic           send_busy;

    ip_uart_tx_arbiter #(
        .NUM_REQ      (N),
        .ACK_TIMEOUT  (ACK_T),
        .IDLE_TIMEOUT (IDLE_T)
    ) dut (
        .sys_clk   (sys_clk),
        .w_n_reset (w_n_reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .arb_busy  (arb_busy),
        .send_data (send_data),
        .send_req  (send_req),
        .send_busy (send_busy)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [10:0] exp_q[$];
    logic [10:0] obs_q[$];
    int          pcyc_q[$];
    int          rel_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          model_ptr = 0;

    // requester FIFOs: {last, byte}
    logic [8:0] src_mem [N][DEPTH];
    int         src_head [N];
    int         src_tail [N];

    // UART model
    int busy_left = 0;
    int busy_len  = 3;
    bit uart_never = 1'b0;

`ifdef UART_ARB_FIXED_PRIO_EN
    int fair_exp [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int probe_exp [2] = '{0, 1};
`else
    int fair_exp [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int probe_exp [2] = '{1, 0};
`endif
    int cont_exp [6] = '{0, 0, 0, 2, 2, 2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = 7;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // ---------------- compare process ----------------
    logic         prev_sreq = 1'b0;
    logic [N-1:0] prev_grant = '0;

    always @(negedge sys_clk) begin
        logic [10:0] got;
        logic [10:0] e;
        if (!w_n_reset) begin
            chk("rst_grant", grant, 0);
            chk("rst_send_req", send_req, 0);
            chk("rst_arb_busy", arb_busy, 0);
            chk("rst_send_data", send_data, 0);
        end else begin
            chk("grant_onehot0", $onehot0(grant), 1);
            chk("arb_busy_vs_grant", arb_busy, grant != 0);
            chk("ready_outside_grant", req_ready & ~grant, 0);
            chk("ready_without_valid", req_ready & ~req_valid, 0);
            chk("ready_while_busy", (req_ready != 0) && send_busy, 0);
            chk("send_req_width", send_req && prev_sreq, 0);
            if (send_req) begin
                got = {3'(onehot_idx(grant)), send_data};
                obs_q.push_back(got);
                pcyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL extra_send_req: got owner/byte %0h, none expected", got);
                end else begin
                    e = exp_q.pop_front();
                    chk("owner_byte", got, e);
                end
            end
            if (prev_grant != 0 && grant == 0) rel_q.push_back(cyc);
        end
        prev_sreq  = send_req;
        prev_grant = grant;
    end

    // ---------------- driver tasks ----------------
    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (src_head[i] < src_tail[i]) begin
                req_valid[i]        = 1'b1;
                req_last[i]         = src_mem[i][src_head[i]][8];
                req_data[i*8 +: 8]  = src_mem[i][src_head[i]][7:0];
            end else begin
                req_valid[i]        = 1'b0;
                req_last[i]         = 1'b0;
                req_data[i*8 +: 8]  = 8'h00;
            end
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] b, input logic l);
        src_mem[r][src_tail[r]] = {l, b};
        src_tail[r]++;
    endtask

    // One clock: sample handshakes at negedge, update stimulus 1 ns after posedge.
    task automatic step();
        logic [N-1:0] rdy;
        logic         sr;
        @(negedge sys_clk);
        rdy = req_ready;
        sr  = send_req;
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < N; i++) if (rdy[i]) src_head[i]++;
        if (sr && !uart_never) busy_left = busy_len;
        else if (busy_left > 0) busy_left--;
        send_busy = (busy_left > 0);
        drive_inputs();
    endtask

    // Packet-level model: whole packets, first pending requester from the
    // pointer upward; a packet without last ends where its bytes run out.
    task automatic run_model();
        int h [N];
        int own;
        int j;
        logic [N-1:0] m;
        logic done;
        for (int i = 0; i < N; i++) h[i] = src_head[i];
        for (int g = 0; g < 64; g++) begin
            for (int i = 0; i < N; i++) m[i] = (h[i] < src_tail[i]);
            if (m == 0) break;
            own = -1;
            for (int k = 0; k < N; k++) begin
                j = (model_ptr + k) % N;
                if (own < 0 && m[j]) own = j;
            end
            done = 1'b0;
            while (!done && h[own] < src_tail[own]) begin
                exp_q.push_back({3'(own), src_mem[own][h[own]][7:0]});
                done = src_mem[own][h[own]][8];
                h[own]++;
            end
`ifdef UART_ARB_FIXED_PRIO_EN
            model_ptr = 0;
`else
            model_ptr = (own + 1) % N;
`endif
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        logic pend;
        k = 0;
        pend = 1'b1;
        while (pend && k < budget) begin
            step();
            k++;
            pend = (exp_q.size() != 0) || arb_busy;
            for (int i = 0; i < N; i++) if (src_head[i] < src_tail[i]) pend = 1'b1;
        end
        chk({name, "_drain_timeout"}, pend, 0);
    endtask

    task automatic clear_obs();
        obs_q.delete();
        pcyc_q.delete();
        rel_q.delete();
    endtask

    task automatic apply_reset();
        w_n_reset = 1'b0;
        busy_left = 0;
        send_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
        drive_inputs();
        exp_q.delete();
        model_ptr = 0;
        repeat (3) step();
        w_n_reset = 1'b1;
    endtask

    task automatic chk_owner_seq(input string name, input int idx, input int exp_own);
        if (obs_q.size() > idx) chk(name, obs_q[idx][10:8], exp_own);
        else chk({name, "_missing"}, obs_q.size(), idx + 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t_load;
        int t_rel;
        int k;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        send_busy = 1'b0;
        apply_reset();

        // reset state after release
        chk("post_rst_grant", grant, 0);
        chk("post_rst_ready", req_ready, 0);
        chk("post_rst_busy", arb_busy, 0);
        chk("post_rst_send_data", send_data, 8'h00);
        chk("post_rst_send_req", send_req, 0);

        // single requester "HI"
        clear_obs();
        push_byte(0, 8'h48, 1'b0);
        push_byte(0, 8'h49, 1'b1);
        drive_inputs();
        t_load = cyc;
        run_model();
        wait_idle(200, "single");
        chk("single_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            chk("single_byte0", obs_q[0], 11'h048);
            chk("single_byte1", obs_q[1], 11'h049);
            chk("single_latency", pcyc_q[0] - t_load, 2);
        end

        // probe: pointer should now favour requester 1
        clear_obs();
        push_byte(0, 8'h70, 1'b1);
        push_byte(1, 8'h71, 1'b1);
        drive_inputs();
        run_model();
        wait_idle(200, "probe");
        chk_owner_seq("probe_owner0", 0, probe_exp[0]);
        chk_owner_seq("probe_owner1", 1, probe_exp[1]);

        // contention from pointer 0
        apply_reset();
        clear_obs();
        push_byte(0, 8'h61, 1'b0); push_byte(0, 8'h62, 1'b0); push_byte(0, 8'h63, 1'b1);
        push_byte(2, 8'h78, 1'b0); push_byte(2, 8'h79, 1'b0); push_byte(2, 8'h7a, 1'b1);
        drive_inputs();
        run_model();
        wait_idle(300, "contention");
        for (int i = 0; i < 6; i++) chk_owner_seq("contention_owner", i, cont_exp[i]);

        // fairness: 1-byte packets from req 0 and req 1
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            push_byte(0, 8'h30 + 8'(i), 1'b1);
            push_byte(1, 8'h40 + 8'(i), 1'b1);
        end
        drive_inputs();
        run_model();
        wait_idle(400, "fairness");
        for (int i = 0; i < 8; i++) chk_owner_seq("fairness_owner", i, fair_exp[i]);

        // ack timeout: UART never raises busy
        clear_obs();
        uart_never = 1'b1;
        push_byte(0, 8'h41, 1'b0);
        push_byte(0, 8'h42, 1'b1);
        drive_inputs();
        t_load = cyc;
        run_model();
        wait_idle(200, "ack_timeout");
        chk("ack_count", pcyc_q.size(), 2);
        if (pcyc_q.size() == 2) begin
            chk("ack_latency", pcyc_q[0] - t_load, 2);
            chk("ack_interval", pcyc_q[1] - pcyc_q[0], 18);
        end
        uart_never = 1'b0;

        // idle timeout: req 1 stops mid-packet, req 3 waits
        apply_reset();
        clear_obs();
        push_byte(1, 8'h58, 1'b0);
        push_byte(3, 8'h5a, 1'b1);
        drive_inputs();
        run_model();
        wait_idle(400, "idle_timeout");
        chk("idle_count", obs_q.size(), 2);
        if (obs_q.size() == 2 && rel_q.size() >= 1) begin
            chk("idle_first", obs_q[0], {3'd1, 8'h58});
            chk("idle_second", obs_q[1], {3'd3, 8'h5a});
            chk("idle_release_cycle", rel_q[0] - pcyc_q[0], 105);
        end else begin
            chk("idle_release_seen", rel_q.size() >= 1, 1);
        end

        // reset during WAIT_DONE with the UART still busy afterwards
        clear_obs();
        busy_len = 6;
        push_byte(2, 8'h4d, 1'b0);
        push_byte(2, 8'h4e, 1'b1);
        drive_inputs();
        run_model();
        k = 0;
        while (obs_q.size() < 1 && k < 50) begin
            step();
            k++;
        end
        chk("rstmid_first_pulse", obs_q.size(), 1);
        step();
        #2;
        w_n_reset = 1'b0;
        #1;
        chk("rstmid_grant", grant, 0);
        chk("rstmid_send_req", send_req, 0);
        chk("rstmid_arb_busy", arb_busy, 0);
        chk("rstmid_ready", req_ready, 0);
        chk("rstmid_send_data", send_data, 8'h00);
        src_head[2] = src_tail[2];
        exp_q.delete();
        model_ptr = 0;
        busy_left = 4;
        drive_inputs();
        step();
        step();
        w_n_reset = 1'b1;
        clear_obs();
        push_byte(2, 8'h4d, 1'b0);
        push_byte(2, 8'h4e, 1'b1);
        drive_inputs();
        t_rel = cyc;
        run_model();
        wait_idle(200, "rstmid_restart");
        chk("rstmid_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            chk("rstmid_byte0", obs_q[0], {3'd2, 8'h4d});
            chk("rstmid_byte1", obs_q[1], {3'd2, 8'h4e});
            chk("rstmid_stall_latency", pcyc_q[0] - t_rel, 3);
        end
        busy_len = 3;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
